mem_arbiter: RTL and testbench

Arbitrates the single main-memory port between the I-cache fill FSM and the D-cache fill FSM; it sits directly downstream of both. A fill FSM owns memory for a whole burst of read words. Each returning word is routed to the fill FSM that owns the burst, together with its data-valid strobe. D-side write-through stores are granted as single-cycle write transactions.

---
 rtl/mem_pkg.sv | 17 +
 rtl/arb_pick.sv | 20 ++
 rtl/mem_arbiter.sv | 150 +++++++++++++++
 tb/tb_mem_arbiter.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the main-memory arbiter slice.
package mem_pkg;

   localparam int unsigned MEM_W           = 16;
   localparam int unsigned BURST_WORDS_DEF = 8;

   typedef enum logic [1:0] {
      IDLE,
      I_BURST,
      D_BURST,
      D_WRITE
   } arb_state_t;

   localparam logic OWN_I = 1'b0;
   localparam logic OWN_D = 1'b1;

endpackage

// File: rtl/arb_pick.sv
// Two-way round-robin tie-break between the I-fill and D-side requesters.
module arb_pick
   import mem_pkg::*;
(
   input  logic i_req,
   input  logic d_req,
   input  logic last_owner,
   output logic winner
);

   always_comb begin
      winner = OWN_I;
      if (i_req && d_req) begin
         winner = (last_owner == OWN_I) ? OWN_D : OWN_I;
      end else if (d_req) begin
         winner = OWN_D;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Main-memory port arbiter: I/D fill bursts and single D-side writes.
// Define ARB_FIXED_PRIO_EN to make the D side win every tie (no last_owner state).
module mem_arbiter
   import mem_pkg::*;
#(
   parameter int unsigned BURST_WORDS = BURST_WORDS_DEF,
   parameter int unsigned CNT_W       = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_req,
   input  logic [MEM_W-1:0] i_addr,
   output logic             i_grant,
   output logic             i_data_valid,
   input  logic             d_req,
   input  logic             d_wr,
   input  logic [MEM_W-1:0] d_addr,
   input  logic [MEM_W-1:0] d_wdata,
   output logic             d_grant,
   output logic             d_data_valid,
   output logic             mem_en,
   output logic             mem_wr,
   output logic [MEM_W-1:0] mem_addr,
   output logic [MEM_W-1:0] mem_wdata,
   input  logic             mem_data_valid,
   input  logic [MEM_W-1:0] mem_rdata
);

   localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(BURST_WORDS);

   arb_state_t       state_q;
   logic [CNT_W-1:0] issued_q;
   logic [CNT_W-1:0] returned_q;

   logic             winner;
   logic             in_burst;
   logic             x_req;
   logic [MEM_W-1:0] x_addr;
   logic             issue_ok;
   logic             burst_grant;
   logic             ret_ok;
   logic [CNT_W-1:0] returned_inc;
   logic [CNT_W-1:0] returned_nxt;
   logic             final_ret;
   logic             abort_done;
   logic             burst_done;

`ifdef ARB_FIXED_PRIO_EN
   assign winner = d_req ? OWN_D : OWN_I;
`else
   logic last_owner_q;

   arb_pick u_arb_pick (
      .i_req      (i_req),
      .d_req      (d_req),
      .last_owner (last_owner_q),
      .winner     (winner)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         last_owner_q <= OWN_I;
      end else if ((state_q == IDLE) && (i_req || d_req)) begin
         last_owner_q <= winner;
      end
   end
`endif

   // Burst bookkeeping shared by both read owners; the state selects whose inputs count.
   always_comb begin
      in_burst     = (state_q == I_BURST) || (state_q == D_BURST);
      x_req        = (state_q == D_BURST) ? d_req : i_req;
      x_addr       = (state_q == D_BURST) ? d_addr : i_addr;
      issue_ok     = issued_q < BURST_MAX;
      burst_grant  = in_burst && x_req && issue_ok;
      ret_ok       = in_burst && mem_data_valid && (returned_q < BURST_MAX);
      returned_inc = returned_q + 1'b1;
      returned_nxt = ret_ok ? returned_inc : returned_q;
      final_ret    = ret_ok && (returned_inc == BURST_MAX);
      // Aborted burst: the owner dropped its request early, finish once all issued words are back.
      abort_done   = in_burst && !x_req && issue_ok && (returned_nxt == issued_q);
      burst_done   = final_ret || abort_done;
   end

   always_comb begin
      i_grant      = (state_q == I_BURST) && burst_grant;
      d_grant      = ((state_q == D_BURST) && burst_grant) || (state_q == D_WRITE);
      i_data_valid = (state_q == I_BURST) && ret_ok;
      d_data_valid = (state_q == D_BURST) && ret_ok;
      mem_en       = burst_grant || (state_q == D_WRITE);
      mem_wr       = (state_q == D_WRITE);
      mem_addr     = '0;
      mem_wdata    = '0;
      if (burst_grant) begin
         mem_addr = x_addr;
      end else if (state_q == D_WRITE) begin
         mem_addr  = d_addr;
         mem_wdata = d_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         issued_q   <= '0;
         returned_q <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (i_req || d_req) begin
                  issued_q   <= '0;
                  returned_q <= '0;
                  if (winner == OWN_D) begin
                     state_q <= d_wr ? D_WRITE : D_BURST;
                  end else begin
                     state_q <= I_BURST;
                  end
               end
            end
            I_BURST, D_BURST: begin
               if (burst_done) begin
                  state_q    <= IDLE;
                  issued_q   <= '0;
                  returned_q <= '0;
               end else begin
                  if (burst_grant) begin
                     issued_q <= issued_q + 1'b1;
                  end
                  if (ret_ok) begin
                     returned_q <= returned_inc;
                  end
               end
            end
            D_WRITE: begin
               state_q    <= IDLE;
               issued_q   <= '0;
               returned_q <= '0;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   // Returned data is fanned out unchanged; only the strobes are routed.
   logic [MEM_W-1:0] rdata_unused;
   assign rdata_unused = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a latency-4 memory model and a return scoreboard.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_req = 1'b0;
   logic [15:0] i_addr = '0;
   logic        i_grant;
   logic        i_data_valid;
   logic        d_req = 1'b0;
   logic        d_wr = 1'b0;
   logic [15:0] d_addr = '0;
   logic [15:0] d_wdata = '0;
   logic        d_grant;
   logic        d_data_valid;
   logic        mem_en;
   logic        mem_wr;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic        mem_data_valid;
   logic [15:0] mem_rdata;

   mem_arbiter dut (
      .clk            (clk),
      .rst            (rst),
      .i_req          (i_req),
      .i_addr         (i_addr),
      .i_grant        (i_grant),
      .i_data_valid   (i_data_valid),
      .d_req          (d_req),
      .d_wr           (d_wr),
      .d_addr         (d_addr),
      .d_wdata        (d_wdata),
      .d_grant        (d_grant),
      .d_data_valid   (d_data_valid),
      .mem_en         (mem_en),
      .mem_wr         (mem_wr),
      .mem_addr       (mem_addr),
      .mem_wdata      (mem_wdata),
      .mem_data_valid (mem_data_valid),
      .mem_rdata      (mem_rdata)
   );

   always #5 clk = ~clk;

   // Memory model: fixed read latency of 4 cycles, not affected by the arbiter reset.
   logic [3:0]  pv = '0;
   logic [15:0] pa [4];
   always @(posedge clk) begin
      pv    <= {pv[2:0], (mem_en === 1'b1) && (mem_wr === 1'b0)};
      pa[0] <= mem_addr;
      pa[1] <= pa[0];
      pa[2] <= pa[1];
      pa[3] <= pa[2];
   end
   assign mem_data_valid = pv[3];
   assign mem_rdata      = pa[3] ^ 16'hC3C3;

   typedef struct packed {
      logic own;
      logic deliver;
   } ret_t;

   ret_t        ret_q[$];
   int          tests = 0;
   int          fails = 0;
   int          cyc = 0;
   int          i_gnt_cnt = 0, d_gnt_cnt = 0, i_dv_cnt = 0, d_dv_cnt = 0;
   int          wr_cnt = 0, wr_cyc = 0;
   logic [15:0] wr_addr, wr_data;
   logic [15:0] i_exp = '0, d_exp = '0;
   logic        mon_on = 1'b0;
   logic        ig_s, dg_s;
   logic [63:0] outs_s;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Sample one cycle mid-period, then apply requester address advances after the edge.
   task automatic tick();
      logic i_adv, d_adv;
      ret_t e;
      i_adv = 1'b0;
      d_adv = 1'b0;
      @(negedge clk);
      cyc++;
      ig_s   = i_grant;
      dg_s   = d_grant;
      outs_s = {26'd0, i_grant, d_grant, i_data_valid, d_data_valid, mem_en, mem_wr,
                mem_addr, mem_wdata};
      if (mon_on) begin
         if (mem_data_valid) begin
            if (ret_q.size() == 0) begin
               chk("orphan_dv", {i_data_valid, d_data_valid}, 2'b00);
            end else begin
               e = ret_q.pop_front();
               chk("i_dv_route", i_data_valid, e.deliver && (e.own == 1'b0));
               chk("d_dv_route", d_data_valid, e.deliver && (e.own == 1'b1));
            end
         end else begin
            chk("dv_quiet", {i_data_valid, d_data_valid}, 2'b00);
         end
         if (i_data_valid) i_dv_cnt++;
         if (d_data_valid) d_dv_cnt++;
         chk("grant_excl", i_grant & d_grant, 1'b0);
         if (mem_en && !i_grant && !d_grant) chk("mem_en_no_grant", mem_en, 1'b0);
         if (i_grant) begin
            chk("i_mem_addr", mem_addr, i_exp);
            chk("i_mem_rd", {mem_en, mem_wr}, 2'b10);
            ret_q.push_back('{own: 1'b0, deliver: 1'b1});
            i_exp = i_exp + 16'd2;
            i_adv = 1'b1;
            i_gnt_cnt++;
         end
         if (d_grant && !mem_wr) begin
            chk("d_mem_addr", mem_addr, d_exp);
            ret_q.push_back('{own: 1'b1, deliver: 1'b1});
            d_exp = d_exp + 16'd2;
            d_adv = 1'b1;
            d_gnt_cnt++;
         end
         if (d_grant && mem_wr) begin
            wr_cnt++;
            wr_cyc  = cyc;
            wr_addr = mem_addr;
            wr_data = mem_wdata;
         end
         if (rst) begin
            foreach (ret_q[k]) ret_q[k].deliver = 1'b0;
         end
      end
      @(posedge clk);
      #1;
      if (i_adv) i_addr = i_addr + 16'd2;
      if (d_adv) d_addr = d_addr + 16'd2;
   endtask

   task automatic drain();
      for (int n = 0; n < 30 && ret_q.size() != 0; n++) tick();
      chk("drain", ret_q.size(), 0);
      repeat (2) tick();
   endtask

   initial begin
      int g0, v0, w0, rc, dg0, dv0;

      // Reset then idle
      rst = 1'b1;
      tick();
      tick();
      mon_on = 1'b1;
      chk("reset_outs", outs_s, 64'd0);
      rst = 1'b0;
      for (int n = 0; n < 4; n++) begin
         tick();
         chk("idle_outs", outs_s, 64'd0);
      end

      // I-only burst, then a back-to-back request aborted after one grant
      i_addr = 16'h1230;
      i_exp  = 16'h1230;
      i_req  = 1'b1;
      g0 = i_gnt_cnt;
      v0 = i_dv_cnt;
      tick();
      chk("i_arb_cycle", ig_s, 1'b0);
      tick();
      chk("i_first_grant", ig_s, 1'b1);
      for (int n = 0; n < 40 && (i_dv_cnt - v0) < 8; n++) tick();
      chk("i_burst_dv", i_dv_cnt - v0, 8);
      chk("i_burst_grants", i_gnt_cnt - g0, 8);
      tick();
      chk("i_idle_after_burst", outs_s, 64'd0);
      tick();
      chk("i_b2b_grant", ig_s, 1'b1);
      i_req = 1'b0;
      drain();
      chk("i_b2b_dv", i_dv_cnt - v0, 9);
      chk("i_burst_no_d_dv", d_dv_cnt, 0);

      // Simultaneous requests from reset: D first, then I
      rst = 1'b1;
      tick();
      rst    = 1'b0;
      i_req  = 1'b1;
      d_req  = 1'b1;
      d_wr   = 1'b0;
      i_addr = 16'h2000;
      i_exp  = 16'h2000;
      d_addr = 16'h3000;
      d_exp  = 16'h3000;
      g0  = i_gnt_cnt;
      dv0 = d_dv_cnt;
      tick();
      chk("tie_arb_cycle", {ig_s, dg_s}, 2'b00);
      tick();
      chk("tie1_d_wins", {ig_s, dg_s}, 2'b01);
      for (int n = 0; n < 40 && (d_dv_cnt - dv0) < 8; n++) tick();
      chk("tie1_d_dv", d_dv_cnt - dv0, 8);
      chk("tie1_i_blocked", i_gnt_cnt - g0, 0);
      tick();
      chk("tie_idle", {ig_s, dg_s}, 2'b00);
      tick();
      chk("tie2_i_wins", {ig_s, dg_s}, 2'b10);
      i_req = 1'b0;
      d_req = 1'b0;
      drain();

      // D write raised mid I burst
      i_addr = 16'h4000;
      i_exp  = 16'h4000;
      i_req  = 1'b1;
      g0 = i_gnt_cnt;
      v0 = i_dv_cnt;
      w0 = wr_cnt;
      for (int n = 0; n < 10 && (i_gnt_cnt - g0) < 2; n++) tick();
      d_req   = 1'b1;
      d_wr    = 1'b1;
      d_addr  = 16'h00A0;
      d_wdata = 16'hBEEF;
      for (int n = 0; n < 40 && (i_dv_cnt - v0) < 8; n++) tick();
      chk("wr_i_burst_dv", i_dv_cnt - v0, 8);
      chk("wr_blocked", wr_cnt - w0, 0);
      i_req = 1'b0;
      rc = cyc;
      for (int n = 0; n < 10 && (wr_cnt - w0) < 1; n++) tick();
      d_req = 1'b0;
      d_wr  = 1'b0;
      chk("wr_latency", wr_cyc - rc, 2);
      chk("wr_addr", wr_addr, 16'h00A0);
      chk("wr_data", wr_data, 16'hBEEF);
      repeat (6) tick();
      chk("wr_single", wr_cnt - w0, 1);
      chk("wr_no_resp", ret_q.size(), 0);

      // Abort after 3 grants
      i_addr = 16'h5000;
      i_exp  = 16'h5000;
      i_req  = 1'b1;
      g0 = i_gnt_cnt;
      v0 = i_dv_cnt;
      for (int n = 0; n < 10 && (i_gnt_cnt - g0) < 3; n++) tick();
      i_req = 1'b0;
      drain();
      chk("abort_grants", i_gnt_cnt - g0, 3);
      chk("abort_dv", i_dv_cnt - v0, 3);

      // Reset mid-burst, stale returns dropped, then a fresh D burst
      i_addr = 16'h6000;
      i_exp  = 16'h6000;
      i_req  = 1'b1;
      g0 = i_gnt_cnt;
      for (int n = 0; n < 10 && (i_gnt_cnt - g0) < 5; n++) tick();
      rst = 1'b1;
      tick();
      rst   = 1'b0;
      i_req = 1'b0;
      v0 = i_dv_cnt;
      tick();
      chk("rst_idle_outs", outs_s, 64'd0);
      drain();
      chk("rst_stale_dropped", (i_dv_cnt - v0) + d_dv_cnt - dv0 - 8, 0);
      d_addr = 16'h7000;
      d_exp  = 16'h7000;
      d_wr   = 1'b0;
      d_req  = 1'b1;
      dg0 = d_gnt_cnt;
      dv0 = d_dv_cnt;
      for (int n = 0; n < 40 && (d_dv_cnt - dv0) < 8; n++) tick();
      d_req = 1'b0;
      chk("fresh_d_dv", d_dv_cnt - dv0, 8);
      chk("fresh_d_grants", d_gnt_cnt - dg0, 8);
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not reach the summary");
      $fatal(1, "timeout");
   end

endmodule
